prim_assembler: RTL and testbench
=================================

// Module: prim_assembler
// PURPOSE
//  Triangle assembly stage between the vertex shader and the hexagonal rasterizer.
//  Accepts a stream of transformed screen-space vertices (valid/ready) and groups them into triangles.
//  Supports list or strip topology and presents v0/v1/v2 to the rasterizer through a registered valid/ready output.
// PARAMETERS
//  COORD_W  32  width of each screen coordinate (x, y)
//  CNT_W    16  width of the saturating statistics counters
// PORTS
//  clk          in   1        system clock
//  reset        in   1        asynchronous, active-low reset
//  mode         in   1        topology: 0 = triangle list, 1 = triangle strip
//  vtx_valid    in   1        input vertex valid
//  vtx_ready    out  1        input vertex accepted when valid&ready
//  vtx_x        in   COORD_W  vertex screen x
//  vtx_y        in   COORD_W  vertex screen y
//  vtx_last     in   1        last vertex of the current primitive batch
//  tri_valid    out  1        triangle valid toward rasterizer
//  tri_ready    in   1        rasterizer accepts triangle
//  tri_v0_x/y   out  COORD_W  triangle vertex 0
//  tri_v1_x/y   out  COORD_W  triangle vertex 1
//  tri_v2_x/y   out  COORD_W  triangle vertex 2
//  tri_count    out  CNT_W    triangles emitted, saturating
//  drop_count   out  CNT_W    batches ended with a partial triangle, saturating
//  cull_count   out  CNT_W    degenerate triangles culled, saturating
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, state S0, parity 0, vertex buffers 0; vtx_ready=1 once released.
//  - vtx_ready = !tri_valid | tri_ready. Combinational from output register state, never from vtx_valid.
//  - Vertex buffer: p0 (older) and p1 (newer). States: S0 (0 held), S1 (1 held), S2 (2 held, none emitted),
//    ST (strip active, triangle already emitted).
//  - mode is sampled only on a vertex handshake in S0 and held for the batch; changes mid-batch are ignored.
//  - Transitions, on a vertex handshake with vertex n:
//    S0 -> S1, p0 <= n.   S1 -> S2, p1 <= n.
//    S2, list:  emit (p0,p1,n), -> S0.
//    S2, strip: emit (p0,p1,n); p0 <= p1; p1 <= n; parity <= 1; -> ST.
//    ST: parity 0 emits (p0,p1,n), parity 1 emits (p1,p0,n); shift p0 <= p1, p1 <= n; toggle parity.
//  - Emit: on the cycle after the completing handshake, the tri_* registers are loaded, tri_valid=1, and
//    tri_count increments. Latency is 1 cycle.
//  - tri_valid & !tri_ready: all tri_* outputs hold stable and no vertex is accepted.
//  - Simultaneous tri handshake and completing vertex handshake: the output is reloaded back-to-back with
//    no bubble. A tri handshake with no new triangle clears tri_valid.
//  - vtx_last on a handshake:
//    - If the vertex completes a triangle, the triangle is emitted.
//    - In every case the state returns to S0 and parity to 0.
//    - If it arrives in S0 or S1 (partial triangle), no triangle is emitted and drop_count increments.
//    - vtx_last in S2 for a list completes normally.
//  - Counters saturate at all-ones and never wrap.
//  - Coordinates pass through unmodified; no arithmetic is applied to vertex data.
//  - Reset mid-batch discards held vertices and any pending output triangle.
// CONFIGURATION
//  PRIM_ASM_CULL_DEGEN_EN defined:
//    - A completed triangle with any two vertices bit-identical (x and y) is degenerate.
//    - It is not emitted; cull_count increments and tri_count does not.
//    - Strip state (p0, p1, parity) still advances as if the triangle were emitted.
//  PRIM_ASM_CULL_DEGEN_EN undefined: every triangle is emitted; cull_count is tied to 0.
// TESTING
//  - List: mode=0; vertices A(0,0) B(4,0) C(0,4) D(8,8) E(9,8) F(8,9), F with last
//    -> (A,B,C) then (D,E,F); tri_count=2.
//  - Strip: mode=1; A..E, E with last -> (A,B,C), (C,B,D), (C,D,E); then S0; tri_count=3.
//  - Backpressure: tri_ready=0 for 3 cycles while a triangle is pending
//    -> vtx_ready=0, tri_* stable; with tri_ready=1 and vtx_valid=1 streaming, one triangle per 3 vertices, no gaps.
//  - Partial batch: list, 2 vertices, second with last -> no tri_valid, drop_count=1; next 3 vertices form a fresh triangle.
//  - Cull (macro on): (1,1),(1,1),(5,7) -> tri_valid stays 0, cull_count=1.
//    Macro off: triangle emitted, cull_count=0.
//  - Reset: reset=0 after 2 list vertices with a triangle pending
//    -> tri_valid=0, all counts 0; after release, 3 vertices -> exactly one triangle from those 3.

Source files
------------

// File: rtl/prim_assembler.sv
// Triangle assembly: groups a screen-space vertex stream into list or strip triangles.
// Optional build macro PRIM_ASM_CULL_DEGEN_EN drops triangles with two bit-identical vertices.
module prim_assembler #(
    parameter int COORD_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic               vtx_valid,
    output logic               vtx_ready,
    input  logic [COORD_W-1:0] vtx_x,
    input  logic [COORD_W-1:0] vtx_y,
    input  logic               vtx_last,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [COORD_W-1:0] tri_v0_x,
    output logic [COORD_W-1:0] tri_v0_y,
    output logic [COORD_W-1:0] tri_v1_x,
    output logic [COORD_W-1:0] tri_v1_y,
    output logic [COORD_W-1:0] tri_v2_x,
    output logic [COORD_W-1:0] tri_v2_y,
    output logic [CNT_W-1:0]   tri_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CNT_W-1:0]   cull_count,
    output logic [1:0]         dbg_state
);

    // Both sides are valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and a stalled output holds all its data.

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, ST = 2'd3} state_e;

    state_e             state_q, state_d;
    logic               parity_q, parity_d;
    logic               mode_q, mode_d;
    logic [COORD_W-1:0] p0_x_q, p0_x_d, p0_y_q, p0_y_d;
    logic [COORD_W-1:0] p1_x_q, p1_x_d, p1_y_q, p1_y_d;
    logic               tv_q, tv_d;
    logic [COORD_W-1:0] t0x_q, t0x_d, t0y_q, t0y_d;
    logic [COORD_W-1:0] t1x_q, t1x_d, t1y_q, t1y_d;
    logic [COORD_W-1:0] t2x_q, t2x_d, t2y_q, t2y_d;
    logic [CNT_W-1:0]   tri_cnt_q, tri_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               hs;
    logic               complete;
    logic               degen;
    logic [COORD_W-1:0] a_x, a_y, b_x, b_y;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign vtx_ready = !tv_q || tri_ready;
    assign hs        = vtx_valid && vtx_ready;
    assign complete  = hs && ((state_q == S2) || (state_q == ST));

    // Odd strip triangles swap the two held vertices to keep a consistent winding.
    always_comb begin
        a_x = p0_x_q;
        a_y = p0_y_q;
        b_x = p1_x_q;
        b_y = p1_y_q;
        if (state_q == ST && parity_q) begin
            a_x = p1_x_q;
            a_y = p1_y_q;
            b_x = p0_x_q;
            b_y = p0_y_q;
        end
    end

`ifdef PRIM_ASM_CULL_DEGEN_EN
    logic [CNT_W-1:0] cull_cnt_q, cull_cnt_d;

    assign degen = ((a_x == b_x) && (a_y == b_y)) ||
                   ((a_x == vtx_x) && (a_y == vtx_y)) ||
                   ((b_x == vtx_x) && (b_y == vtx_y));

    always_comb begin
        cull_cnt_d = cull_cnt_q;
        if (complete && degen) cull_cnt_d = sat_inc(cull_cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cull_cnt_q <= '0;
        else        cull_cnt_q <= cull_cnt_d;
    end

    assign cull_count = cull_cnt_q;
`else
    assign degen      = 1'b0;
    assign cull_count = '0;
`endif

    always_comb begin
        state_d    = state_q;
        parity_d   = parity_q;
        mode_d     = mode_q;
        p0_x_d     = p0_x_q;
        p0_y_d     = p0_y_q;
        p1_x_d     = p1_x_q;
        p1_y_d     = p1_y_q;
        drop_cnt_d = drop_cnt_q;
        if (hs) begin
            unique case (state_q)
                S0: begin
                    p0_x_d = vtx_x;
                    p0_y_d = vtx_y;
                    mode_d = mode;
                    if (vtx_last) drop_cnt_d = sat_inc(drop_cnt_q);
                    else          state_d = S1;
                end
                S1: begin
                    p1_x_d = vtx_x;
                    p1_y_d = vtx_y;
                    if (vtx_last) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = S0;
                    end else begin
                        state_d = S2;
                    end
                end
                default: begin
                    // S2 or ST: this vertex completes a triangle
                    if (vtx_last || (state_q == S2 && !mode_q)) begin
                        state_d  = S0;
                        parity_d = 1'b0;
                    end else begin
                        p0_x_d   = p1_x_q;
                        p0_y_d   = p1_y_q;
                        p1_x_d   = vtx_x;
                        p1_y_d   = vtx_y;
                        parity_d = (state_q == S2) ? 1'b1 : !parity_q;
                        state_d  = ST;
                    end
                end
            endcase
        end
    end

    always_comb begin
        tv_d      = tv_q;
        t0x_d     = t0x_q;
        t0y_d     = t0y_q;
        t1x_d     = t1x_q;
        t1y_d     = t1y_q;
        t2x_d     = t2x_q;
        t2y_d     = t2y_q;
        tri_cnt_d = tri_cnt_q;
        if (complete && !degen) begin
            tv_d      = 1'b1;
            t0x_d     = a_x;
            t0y_d     = a_y;
            t1x_d     = b_x;
            t1y_d     = b_y;
            t2x_d     = vtx_x;
            t2y_d     = vtx_y;
            tri_cnt_d = sat_inc(tri_cnt_q);
        end else if (tri_ready) begin
            tv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S0;
            parity_q   <= 1'b0;
            mode_q     <= 1'b0;
            p0_x_q     <= '0;
            p0_y_q     <= '0;
            p1_x_q     <= '0;
            p1_y_q     <= '0;
            tv_q       <= 1'b0;
            t0x_q      <= '0;
            t0y_q      <= '0;
            t1x_q      <= '0;
            t1y_q      <= '0;
            t2x_q      <= '0;
            t2y_q      <= '0;
            tri_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            parity_q   <= parity_d;
            mode_q     <= mode_d;
            p0_x_q     <= p0_x_d;
            p0_y_q     <= p0_y_d;
            p1_x_q     <= p1_x_d;
            p1_y_q     <= p1_y_d;
            tv_q       <= tv_d;
            t0x_q      <= t0x_d;
            t0y_q      <= t0y_d;
            t1x_q      <= t1x_d;
            t1y_q      <= t1y_d;
            t2x_q      <= t2x_d;
            t2y_q      <= t2y_d;
            tri_cnt_q  <= tri_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tri_valid  = tv_q;
    assign tri_v0_x   = t0x_q;
    assign tri_v0_y   = t0y_q;
    assign tri_v1_x   = t1x_q;
    assign tri_v1_y   = t1y_q;
    assign tri_v2_x   = t2x_q;
    assign tri_v2_y   = t2y_q;
    assign tri_count  = tri_cnt_q;
    assign drop_count = drop_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_prim_assembler.sv
// Randomized bench for prim_assembler against a vertex-queue reference model.
module tb_prim_assembler;
  localparam int W = 16;
  localparam int CW = 4;
  localparam int VW = 2 * W;
  localparam int TW = 6 * W;
  localparam int SAT = (1 << CW) - 1;

  logic clk, reset, mode, vtx_valid, vtx_ready, vtx_last, tri_valid, tri_ready;
  logic [W-1:0] vtx_x, vtx_y;
  logic [W-1:0] tri_v0_x, tri_v0_y, tri_v1_x, tri_v1_y, tri_v2_x, tri_v2_y;
  logic [CW-1:0] tri_count, drop_count, cull_count;
  logic [1:0] dbg_state;

  prim_assembler #(.COORD_W(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_last(vtx_last),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v0_x(tri_v0_x), .tri_v0_y(tri_v0_y),
    .tri_v1_x(tri_v1_x), .tri_v1_y(tri_v1_y),
    .tri_v2_x(tri_v2_x), .tri_v2_y(tri_v2_y),
    .tri_count(tri_count), .drop_count(drop_count), .cull_count(cull_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [TW-1:0] exp_q[$];
  logic [VW-1:0] bq[$];
  logic bmode = 1'b0;
  int m_tri = 0, m_drop = 0, m_cull = 0;
  logic stall_prev = 1'b0;
  logic [TW-1:0] held = '0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] tri_bus();
    return {tri_v0_x, tri_v0_y, tri_v1_x, tri_v1_y, tri_v2_x, tri_v2_y};
  endfunction

  task automatic model_emit(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
    logic dg;
    dg = 1'b0;
`ifdef PRIM_ASM_CULL_DEGEN_EN
    dg = (a == b) || (a == c) || (b == c);
`endif
    if (dg) begin
      if (m_cull < SAT) m_cull++;
    end else begin
      exp_q.push_back({a, b, c});
      if (m_tri < SAT) m_tri++;
    end
  endtask

  // Batch-level rules: list groups every 3 vertices, strip triangle k uses vertices k..k+2
  task automatic model_accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic l, input logic m);
    int n, k;
    if (bq.size() == 0) bmode = m;
    bq.push_back({x, y});
    n = bq.size();
    if (!bmode) begin
      if (n == 3) begin
        model_emit(bq[0], bq[1], bq[2]);
        bq.delete();
      end
    end else if (n >= 3) begin
      k = n - 3;
      if (k % 2 == 0) model_emit(bq[k], bq[k+1], bq[k+2]);
      else            model_emit(bq[k+1], bq[k], bq[k+2]);
    end
    if (l) begin
      if ((!bmode && bq.size() != 0) || (bmode && n < 3)) begin
        if (m_drop < SAT) m_drop++;
      end
      bq.delete();
    end
  endtask

  // driver: one clock cycle; inputs at negedge, observation 1ns later, edge follows
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic l, input logic m, input logic tr, output logic vhs);
    logic [TW-1:0] e;
    @(negedge clk);
    vtx_valid = v; vtx_x = x; vtx_y = y; vtx_last = l; mode = m; tri_ready = tr;
    #1;
    check("vtx_ready", vtx_ready, !tri_valid || tri_ready);
    check("tri_valid", tri_valid, exp_q.size() != 0);
    check("tri_count", tri_count, m_tri);
    check("drop_count", drop_count, m_drop);
    check("cull_count", cull_count, m_cull);
    if (stall_prev) check("stall_hold", tri_bus(), held);
    stall_prev = tri_valid && !tri_ready;
    held = tri_bus();
    if (tri_valid && tri_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("triangle", tri_bus(), e);
    end
    vhs = v && vtx_ready;
    if (vhs) model_accept(x, y, l, m);
  endtask

  task automatic send_vtx(input logic [W-1:0] x, input logic [W-1:0] y, input logic l,
                          input logic m, input int tr_pct);
    logic vhs;
    vhs = 1'b0;
    for (int t = 0; t < 100; t++) begin
      step(1'b1, x, y, l, m, ($urandom_range(0, 99) < tr_pct), vhs);
      if (vhs) break;
    end
    if (!vhs) check("vtx_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic vhs;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, vhs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; vtx_valid = 1'b0; vtx_last = 1'b0; tri_ready = 1'b0;
    #1;
    check("rst_tri_valid", tri_valid, 0);
    check("rst_tri_bus", tri_bus(), 0);
    check("rst_counts", {tri_count, drop_count, cull_count}, 0);
    check("rst_state", dbg_state, 0);
    exp_q.delete(); bq.delete();
    m_tri = 0; m_drop = 0; m_cull = 0; stall_prev = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_vtx_ready", vtx_ready, 1);
  endtask

  function automatic logic [W-1:0] rnd_coord();
    return ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
  endfunction

  initial begin
    logic vhs;
    int len;
    reset = 1'b0; mode = 1'b0; vtx_valid = 1'b0; vtx_last = 1'b0;
    vtx_x = '0; vtx_y = '0; tri_ready = 1'b0;
    do_reset();

    // list A..F
    send_vtx(0, 0, 0, 0, 100); send_vtx(4, 0, 0, 0, 100); send_vtx(0, 4, 0, 0, 100);
    send_vtx(8, 8, 0, 0, 100); send_vtx(9, 8, 0, 0, 100); send_vtx(8, 9, 1, 0, 100);
    idle(3);
    check("list_tri_count", tri_count, 2);

    // strip A..E, mode toggled mid-batch must be ignored
    send_vtx(0, 0, 0, 1, 100); send_vtx(4, 0, 0, 0, 100); send_vtx(0, 4, 0, 1, 100);
    send_vtx(8, 8, 0, 0, 100); send_vtx(9, 8, 1, 1, 100);
    idle(3);
    check("strip_state", dbg_state, 0);

    // backpressure then gapless streaming
    send_vtx(1, 2, 0, 0, 100); send_vtx(3, 4, 0, 0, 100); send_vtx(5, 6, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'd7, 16'd7, 1'b0, 1'b0, 1'b0, vhs);
      check("bp_no_accept", vhs, 0);
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b1, W'(20 + i), W'(40 + i), 1'b0, 1'b0, 1'b1, vhs);
      check("stream_accept", vhs, 1);
    end
    idle(3);

    // partial batch then fresh triangle
    send_vtx(1, 1, 0, 0, 100); send_vtx(2, 2, 1, 0, 100);
    send_vtx(3, 3, 0, 0, 100); send_vtx(4, 4, 0, 0, 100); send_vtx(5, 5, 0, 0, 100);
    idle(3);

    // degenerate triangle
    send_vtx(1, 1, 0, 0, 100); send_vtx(1, 1, 0, 0, 100); send_vtx(5, 7, 0, 0, 100);
    idle(3);

    // reset with a triangle pending, then with two vertices held
    send_vtx(10, 0, 0, 0, 0); send_vtx(11, 0, 0, 0, 0); send_vtx(12, 0, 0, 0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, vhs);
    do_reset();
    send_vtx(13, 0, 0, 0, 100); send_vtx(14, 0, 0, 0, 100);
    do_reset();
    send_vtx(15, 1, 0, 0, 100); send_vtx(16, 1, 0, 0, 100); send_vtx(17, 1, 0, 0, 100);
    idle(3);
    check("post_reset_tri", tri_count, 1);

    // random batches, reaching counter saturation
    for (int b = 0; b < 90; b++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        if (b == 45 && i == 2) do_reset();
        send_vtx(rnd_coord(), rnd_coord(), (i == len - 1), $urandom_range(0, 1), 70);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
    end
    idle(4);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
